// File: rtl/ov7670_sensor_model_pkg.sv
// Shared constants, pattern codes, colour-bar table and FSM encoding for the OV7670 emulator.
package ov7670_sensor_model_pkg;

  localparam int unsigned DefHActive    = 320;
  localparam int unsigned DefVActive    = 240;
  localparam int unsigned DefHBlank     = 144;
  localparam int unsigned DefVsyncLines = 3;
  localparam int unsigned DefVBack      = 17;
  localparam int unsigned DefVFront     = 10;
  localparam logic [15:0] DefSolidValue = 16'hA55A;

  typedef enum logic [1:0] {
    PatBars,
    PatCount,
    PatSolid,
    PatFrame
  } pattern_e;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVBack,
    StActive,
    StVFront
  } state_e;

  // RGB565 colour bars, left to right.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern source: pixel word for (x, y) under the selected pattern.
module ov7670_pattern_gen
  import ov7670_sensor_model_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter logic [15:0] SOLID_VALUE = DefSolidValue
) (
  input  logic [15:0] x_i,
  input  logic [7:0]  y_i,
  input  pattern_e    pattern_i,
  input  logic [15:0] frame_count_i,
  output logic [15:0] word_o
);

  localparam int unsigned BarW = H_ACTIVE / 8;

  logic [2:0] bar;

  // Threshold compare instead of a divide so non-power-of-two bar widths stay cheap.
  always_comb begin
    bar = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x_i) >= i * BarW) bar = 3'(i);
    end
  end

  always_comb begin
    word_o = '0;
    unique case (pattern_i)
      PatBars:  word_o = bar_colour(bar);
      PatCount: word_o = {y_i, x_i[7:0]};
      PatSolid: word_o = SOLID_VALUE;
      PatFrame: word_o = frame_count_i;
      default:  word_o = '0;
    endcase
  end

endmodule

// File: rtl/ov7670_sensor_model.sv
// OV7670 sensor emulator: PCLK divider, frame FSM, line/column counters and byte mux.
module ov7670_sensor_model
  import ov7670_sensor_model_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned H_BLANK     = DefHBlank,
  parameter int unsigned VSYNC_LINES = DefVsyncLines,
  parameter int unsigned V_BACK      = DefVBack,
  parameter int unsigned V_FRONT     = DefVFront,
  parameter logic [15:0] SOLID_VALUE = DefSolidValue
) (
  input  logic        main_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        PCLK,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  CAM_DATA_OUT,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned HTotal  = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] ColLast = 16'(HTotal - 1);
  localparam logic [15:0] HrefEnd = 16'(2 * H_ACTIVE);

  state_e      state_q, state_d;
  pattern_e    pattern_q, pattern_d;
  logic [15:0] col_q, col_d, line_q, line_d, frame_count_q, frame_count_d;
  logic [15:0] line_last, word;
  logic        pclk_q, vsync_q, href_q, href_d, done_q, done_d;
  logic [7:0]  data_q;

  always_comb begin
    line_last = '0;
    unique case (state_q)
      StVsync:  line_last = 16'(VSYNC_LINES - 1);
      StVBack:  line_last = 16'(V_BACK - 1);
      StActive: line_last = 16'(V_ACTIVE - 1);
      StVFront: line_last = 16'(V_FRONT - 1);
      default:  line_last = '0;
    endcase
  end

  // pclk_q high means PCLK falls at this edge: that edge is the tick.
  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    col_d         = col_q;
    line_d        = line_q;
    frame_count_d = frame_count_q;
    done_d        = 1'b0;
    if (pclk_q) begin
      if (state_q == StIdle) begin
        if (enable) begin
          state_d   = StVsync;
          pattern_d = pattern_e'(pattern_sel);
          col_d     = '0;
          line_d    = '0;
        end
      end else if (col_q == ColLast) begin
        col_d  = '0;
        line_d = line_q + 16'd1;
        if (line_q == line_last) begin
          line_d = '0;
          unique case (state_q)
            StVsync:  state_d = StVBack;
            StVBack:  state_d = StActive;
            StActive: state_d = StVFront;
            default: begin
              done_d        = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = enable ? StVsync : StIdle;
              if (enable) pattern_d = pattern_e'(pattern_sel);
            end
          endcase
        end
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  assign href_d = (state_d == StActive) && (col_d < HrefEnd);

  ov7670_pattern_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .SOLID_VALUE (SOLID_VALUE)
  ) u_pattern_gen (
    .x_i           ({1'b0, col_d[15:1]}),
    .y_i           (line_d[7:0]),
    .pattern_i     (pattern_d),
    .frame_count_i (frame_count_d),
    .word_o        (word)
  );

  always_ff @(posedge main_clk) begin
    if (!rst_n) begin
      pclk_q        <= 1'b0;
      state_q       <= StIdle;
      pattern_q     <= PatBars;
      col_q         <= '0;
      line_q        <= '0;
      frame_count_q <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      pclk_q        <= ~pclk_q;
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      col_q         <= col_d;
      line_q        <= line_d;
      frame_count_q <= frame_count_d;
      vsync_q       <= (state_d == StVsync);
      href_q        <= href_d;
      data_q        <= href_d ? (col_d[0] ? word[15:8] : word[7:0]) : 8'h00;
      done_q        <= done_d;
    end
  end

  assign PCLK         = pclk_q;
  assign VSYNC        = vsync_q;
  assign HREF         = href_q;
  assign CAM_DATA_OUT = data_q;
  assign frame_done   = done_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_ov7670_sensor_model.sv
// Bench for ov7670_sensor_model with small timing parameters: frame timing, patterns, enable, reset.
module tb_ov7670_sensor_model;

  localparam int HA = 8, VA = 2, HB = 4, VL = 1, VBK = 1, VF = 1;
  localparam int HT = 2 * HA + HB;        // 20 PCLK per line
  localparam int FRAME = (VL + VBK + VA + VF) * HT;  // 100 PCLK per frame

  logic        clk, rst_n, enable;
  logic [1:0]  pattern_sel;
  logic        PCLK, VSYNC, HREF, frame_done;
  logic [7:0]  CAM_DATA_OUT;
  logic [15:0] frame_count;

  ov7670_sensor_model #(
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VL),
    .V_BACK      (VBK),
    .V_FRONT     (VF),
    .SOLID_VALUE (16'hA55A)
  ) dut (
    .main_clk     (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pattern_sel  (pattern_sel),
    .PCLK         (PCLK),
    .VSYNC        (VSYNC),
    .HREF         (HREF),
    .CAM_DATA_OUT (CAM_DATA_OUT),
    .frame_done   (frame_done),
    .frame_count  (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one sample per PCLK period, just after PCLK rises.
  logic [7:0] cap [2][16];
  int since = 0, period = 0, vs_len = 0, href_off = 0, hlen = 0, last_hlen = 0;
  int mon_line = 0, col = 0, href_pulses = 0, vs_rises = 0, idle_nz = 0;
  int done_cnt = 0, count_at_done = -1;
  logic prev_vs = 1'b0, prev_href = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        done_cnt++;
        count_at_done = int'(frame_count);
      end
      if (rst_n === 1'b1 && PCLK === 1'b1) begin
        if (VSYNC && !prev_vs) begin
          period = since + 1;
          since = 0; vs_len = 0; mon_line = 0; href_pulses = 0;
          vs_rises++;
        end else begin
          since++;
        end
        if (VSYNC) vs_len++;
        if (HREF) begin
          if (!prev_href) begin
            col = 0; hlen = 0;
            if (mon_line == 0) href_off = since;
          end
          if (mon_line < 2 && col < 16) cap[mon_line][col] = CAM_DATA_OUT;
          col++; hlen++;
        end else begin
          if (CAM_DATA_OUT != 8'h00) idle_nz++;
          if (prev_href) begin
            last_hlen = hlen; mon_line++; href_pulses++;
          end
        end
        prev_vs = VSYNC;
        prev_href = HREF;
      end
    end
  end

  task automatic wait_done(input string name);
    int start;
    bit seen;
    start = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s: frame_done not seen within %0d cycles", name, 4 * FRAME);
    end
  endtask

  typedef struct {
    int pat;
    int line;
    int x;
    int lo;
    int hi;
  } vec_t;
  vec_t vecs [10];

  task automatic check_vectors(input int p);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pat == p) begin
        chk($sformatf("pat%0d y%0d x%0d lo", p, vecs[i].line, vecs[i].x),
            int'(cap[vecs[i].line][2 * vecs[i].x]), vecs[i].lo);
        chk($sformatf("pat%0d y%0d x%0d hi", p, vecs[i].line, vecs[i].x),
            int'(cap[vecs[i].line][2 * vecs[i].x + 1]), vecs[i].hi);
      end
    end
  endtask

  initial begin
    int errs, exp, rises0;
    bit found;

    vecs[0] = '{0, 0, 0, 8'hFF, 8'hFF};
    vecs[1] = '{0, 0, 1, 8'hE0, 8'hFF};
    vecs[2] = '{0, 1, 4, 8'h1F, 8'hF8};
    vecs[3] = '{0, 1, 7, 8'h00, 8'h00};
    vecs[4] = '{1, 0, 0, 8'h00, 8'h00};
    vecs[5] = '{1, 1, 5, 8'h05, 8'h01};
    vecs[6] = '{1, 1, 7, 8'h07, 8'h01};
    vecs[7] = '{1, 0, 3, 8'h03, 8'h00};
    vecs[8] = '{2, 1, 3, 8'h5A, 8'hA5};
    vecs[9] = '{2, 0, 0, 8'h5A, 8'hA5};

    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset PCLK", int'(PCLK), 0);
    chk("reset VSYNC", int'(VSYNC), 0);
    chk("reset HREF", int'(HREF), 0);
    chk("reset data", int'(CAM_DATA_OUT), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset frame_count", int'(frame_count), 0);

    // Frame 0: bars; switch pattern_sel mid-frame, which must not affect this frame.
    rst_n = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    chk("first PCLK rise", int'(PCLK), 1);
    chk("no VSYNC before tick", int'(VSYNC), 0);
    @(posedge clk); #1;
    chk("start latency VSYNC", int'(VSYNC), 1);
    repeat (10) @(posedge clk);
    pattern_sel = 2'd1;
    wait_done("frame0");
    chk("vsync length", vs_len, VL * HT);
    chk("vsync to href", href_off, (VL + VBK) * HT);
    chk("href length", last_hlen, 2 * HA);
    chk("href pulses f0", href_pulses, VA);
    chk("count at done f0", count_at_done, 1);
    check_vectors(0);

    pattern_sel = 2'd2;
    wait_done("frame1");
    chk("frame period", period, FRAME);
    chk("count at done f1", count_at_done, 2);
    check_vectors(1);

    // Frame 2: solid; drop enable during its second active line.
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk); #1;
      if (HREF && mon_line == 1) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached line 1 of frame2", int'(found), 1);
    enable = 1'b0;
    wait_done("frame2");
    chk("href pulses f2", href_pulses, VA);
    chk("frame_count after drop", int'(frame_count), 3);
    chk("done pulses", done_cnt, 3);
    check_vectors(2);
    rises0 = vs_rises;
    repeat (3 * FRAME) @(negedge clk);
    chk("idle no vsync", vs_rises, rises0);
    chk("idle VSYNC", int'(VSYNC), 0);
    chk("idle HREF", int'(HREF), 0);
    chk("idle done pulses", done_cnt, 3);

    // Mid-line reset, then restart with pattern 3.
    pattern_sel = 2'd3; enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (HREF) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached href before reset", int'(found), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid reset PCLK", int'(PCLK), 0);
    chk("mid reset VSYNC", int'(VSYNC), 0);
    chk("mid reset HREF", int'(HREF), 0);
    chk("mid reset data", int'(CAM_DATA_OUT), 0);
    chk("mid reset frame_count", int'(frame_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart PCLK", int'(PCLK), 1);
    @(posedge clk); #1;
    chk("restart VSYNC", int'(VSYNC), 1);

    for (int f = 0; f < 3; f++) begin
      wait_done($sformatf("pat3 frame%0d", f));
      if (f == 0) begin
        chk("restart vsync length", vs_len, VL * HT);
        chk("restart vsync to href", href_off, (VL + VBK) * HT);
      end
      errs = 0;
      for (int l = 0; l < VA; l++) begin
        for (int c = 0; c < 2 * HA; c++) begin
          exp = (c % 2 == 0) ? f : 0;
          if (int'(cap[l][c]) != exp) errs++;
        end
      end
      chk($sformatf("pat3 frame%0d byte errors", f), errs, 0);
      chk($sformatf("pat3 count at done %0d", f), count_at_done, f + 1);
    end

    // Preload frame_count to FFFF during VSYNC of the next frame and let it wrap.
    repeat (4) @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    wait_done("wrap frame");
    chk("wrap pixel lo", int'(cap[0][0]), 8'hFF);
    chk("wrap pixel hi", int'(cap[0][1]), 8'hFF);
    chk("wrap count at done", count_at_done, 0);
    chk("wrap frame_count", int'(frame_count), 0);
    chk("data zero outside href", idle_nz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
